ecc_err_monitor: RTL and testbench

- Sits directly downstream of `ecc_dec` and consumes its per-word flags and syndrome.
- Counts single-bit and double-bit events in saturating counters and captures the first unacknowledged error (address, syndrome, type) in a log register.
- Flags a lost-log overflow and raises a level interrupt on any uncorrectable error or when a single-bit threshold is reached.
- Software or the scrub controller reads the log, acknowledges it, and clears the counters.

---
 rtl/ecc_err_monitor.sv | 144 ++++++++++++++
 tb/tb_ecc_err_monitor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ecc_err_monitor.sv
// ECC error monitor: saturating SB/DB event counters, first-error log with overflow flag, level irq.
// One-cycle registered latency on all outputs; never stalls the decoder.
module ecc_err_monitor #(
    parameter int SYN_W     = 7,
    parameter int AW        = 32,
    parameter int CNT_W     = 16,
    parameter int SB_THRESH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [SYN_W-1:0] syndrome_i,
    input  logic             sb_err_i,
    input  logic             db_err_i,
    input  logic             sb_fix_i,
    input  logic             ack_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] sb_cnt_o,
    output logic [CNT_W-1:0] db_cnt_o,
    output logic             log_valid_o,
    output logic             log_db_o,
    output logic             log_fix_o,
    output logic [AW-1:0]    log_addr_o,
    output logic [SYN_W-1:0] log_syn_o,
    output logic             ovf_o,
    output logic             irq_o
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_sb_cnt;
    logic [CNT_W-1:0]   r_db_cnt;
    logic [CNT_W-1:0]   w_sb_cnt_nxt;
    logic [CNT_W-1:0]   w_db_cnt_nxt;
    logic               r_log_db;
    logic               r_log_fix;
    logic [AW-1:0]      r_log_addr;
    logic [SYN_W-1:0]   r_log_syn;
    logic               r_ovf;
    logic               r_irq;
    logic               w_ovf_nxt;
    logic               w_irq_nxt;
    logic               w_capture;
    logic               w_log_clear;
    logic               w_sb_evt;
    logic               w_db_evt;
    logic               w_evt;

    // A double-bit flag dominates the single-bit flag.
    assign w_db_evt = valid_i & db_err_i;
    assign w_sb_evt = valid_i & sb_err_i & ~db_err_i;
    assign w_evt    = w_db_evt | w_sb_evt;

    always_comb begin
        w_state_nxt  = r_state;
        w_sb_cnt_nxt = r_sb_cnt;
        w_db_cnt_nxt = r_db_cnt;
        w_ovf_nxt    = r_ovf;
        w_capture    = 1'b0;
        w_log_clear  = 1'b0;
        if (clr_i) begin
            w_state_nxt  = ST_EMPTY;
            w_sb_cnt_nxt = '0;
            w_db_cnt_nxt = '0;
            w_ovf_nxt    = 1'b0;
            w_log_clear  = 1'b1;
        end else begin
            if (w_sb_evt && (r_sb_cnt != CNT_MAX)) w_sb_cnt_nxt = r_sb_cnt + 1'b1;
            if (w_db_evt && (r_db_cnt != CNT_MAX)) w_db_cnt_nxt = r_db_cnt + 1'b1;
            case (r_state)
                ST_EMPTY: begin
                    if (w_evt) begin
                        w_state_nxt = ST_HELD;
                        w_capture   = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (ack_i) begin
                        // An event arriving with the ack is the new first error.
                        w_ovf_nxt = 1'b0;
                        if (w_evt) w_capture = 1'b1;
                        else       w_state_nxt = ST_EMPTY;
                    end else if (w_evt) begin
                        w_ovf_nxt = 1'b1;
                        if (w_db_evt && !r_log_db) w_capture = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
        w_irq_nxt = (w_db_cnt_nxt != '0) ||
                    ((SB_THRESH != 0) && (64'(w_sb_cnt_nxt) >= 64'(SB_THRESH)));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_EMPTY;
            r_sb_cnt   <= '0;
            r_db_cnt   <= '0;
            r_ovf      <= 1'b0;
            r_irq      <= 1'b0;
            r_log_db   <= 1'b0;
            r_log_fix  <= 1'b0;
            r_log_addr <= '0;
            r_log_syn  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sb_cnt <= w_sb_cnt_nxt;
            r_db_cnt <= w_db_cnt_nxt;
            r_ovf    <= w_ovf_nxt;
            r_irq    <= w_irq_nxt;
            if (w_log_clear) begin
                r_log_db   <= 1'b0;
                r_log_fix  <= 1'b0;
                r_log_addr <= '0;
                r_log_syn  <= '0;
            end else if (w_capture) begin
                r_log_db   <= w_db_evt;
                r_log_fix  <= sb_fix_i & ~w_db_evt;
                r_log_addr <= addr_i;
                r_log_syn  <= syndrome_i;
            end
        end
    end

    assign sb_cnt_o    = r_sb_cnt;
    assign db_cnt_o    = r_db_cnt;
    assign log_valid_o = (r_state == ST_HELD);
    assign log_db_o    = r_log_db;
    assign log_fix_o   = r_log_fix;
    assign log_addr_o  = r_log_addr;
    assign log_syn_o   = r_log_syn;
    assign ovf_o       = r_ovf;
    assign irq_o       = r_irq;

endmodule

// File: tb/tb_ecc_err_monitor.sv
// Randomized and directed bench for ecc_err_monitor against an in-bench behavioural model.
module tb_ecc_err_monitor;

    localparam int SYN_W  = 7;
    localparam int AW     = 32;
    localparam int CNT_W  = 4;
    localparam int THRESH = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             valid_i = 1'b0;
    logic [AW-1:0]    addr_i = '0;
    logic [SYN_W-1:0] syndrome_i = '0;
    logic             sb_err_i = 1'b0;
    logic             db_err_i = 1'b0;
    logic             sb_fix_i = 1'b0;
    logic             ack_i = 1'b0;
    logic             clr_i = 1'b0;
    logic [CNT_W-1:0] sb_cnt_o;
    logic [CNT_W-1:0] db_cnt_o;
    logic             log_valid_o;
    logic             log_db_o;
    logic             log_fix_o;
    logic [AW-1:0]    log_addr_o;
    logic [SYN_W-1:0] log_syn_o;
    logic             ovf_o;
    logic             irq_o;

    integer tests = 0;
    integer fails = 0;
    bit     chk_en = 1'b0;

    always #5 clk = ~clk;

    ecc_err_monitor #(
        .SYN_W(SYN_W), .AW(AW), .CNT_W(CNT_W), .SB_THRESH(THRESH)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .addr_i(addr_i),
        .syndrome_i(syndrome_i), .sb_err_i(sb_err_i), .db_err_i(db_err_i),
        .sb_fix_i(sb_fix_i), .ack_i(ack_i), .clr_i(clr_i),
        .sb_cnt_o(sb_cnt_o), .db_cnt_o(db_cnt_o), .log_valid_o(log_valid_o),
        .log_db_o(log_db_o), .log_fix_o(log_fix_o), .log_addr_o(log_addr_o),
        .log_syn_o(log_syn_o), .ovf_o(ovf_o), .irq_o(irq_o)
    );

    typedef struct packed {
        int               sb;
        int               db;
        bit               lv;
        bit               ldb;
        bit               lfix;
        logic [AW-1:0]    addr;
        logic [SYN_W-1:0] syn;
        bit               ovf;
        bit               irq;
    } mdl_t;

    mdl_t m = '0;

    function automatic mdl_t mnext(mdl_t c, bit rst, bit v, bit sb, bit db, bit fix,
                                   bit ack, bit clr, logic [AW-1:0] a, logic [SYN_W-1:0] s);
        mdl_t n = c;
        bit is_db = v && db;
        bit is_sb = v && sb && !db;
        bit ev = is_db || is_sb;
        bit take = 1'b0;
        if (rst || clr) return '0;
        if (is_sb) n.sb = (c.sb + 1 > CMAX) ? CMAX : c.sb + 1;
        if (is_db) n.db = (c.db + 1 > CMAX) ? CMAX : c.db + 1;
        if (!c.lv) take = ev;
        else if (ack) begin
            n.ovf = 1'b0;
            if (!ev) n.lv = 1'b0;
            take = ev;
        end else if (ev) begin
            n.ovf = 1'b1;
            take = is_db && !c.ldb;
        end
        if (take) begin
            n.lv = 1'b1; n.addr = a; n.syn = s; n.ldb = is_db; n.lfix = fix && !is_db;
        end
        n.irq = (n.db != 0) || (THRESH != 0 && n.sb >= THRESH);
        return n;
    endfunction

    always @(posedge clk)
        m <= mnext(m, rst_i, valid_i, sb_err_i, db_err_i, sb_fix_i, ack_i, clr_i, addr_i, syndrome_i);

    always @(negedge clk) begin
        if (chk_en) begin
            tests = tests + 1;
            if (int'(sb_cnt_o) != m.sb || int'(db_cnt_o) != m.db || log_valid_o != m.lv ||
                log_db_o != m.ldb || log_fix_o != m.lfix || log_addr_o != m.addr ||
                log_syn_o != m.syn || ovf_o != m.ovf || irq_o != m.irq) begin
                fails = fails + 1;
                $display("FAIL model t=%0t got sb=%0d db=%0d lv=%b ldb=%b fix=%b a=%h s=%h ovf=%b irq=%b want sb=%0d db=%0d lv=%b ldb=%b fix=%b a=%h s=%h ovf=%b irq=%b",
                         $time, sb_cnt_o, db_cnt_o, log_valid_o, log_db_o, log_fix_o, log_addr_o,
                         log_syn_o, ovf_o, irq_o, m.sb, m.db, m.lv, m.ldb, m.lfix, m.addr, m.syn,
                         m.ovf, m.irq);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, then return inputs to idle.
    task automatic tick(input bit v, input logic [AW-1:0] a, input logic [SYN_W-1:0] s,
                        input bit sb, input bit db, input bit fix, input bit ack,
                        input bit clr, input bit rst);
        valid_i = v; addr_i = a; syndrome_i = s; sb_err_i = sb; db_err_i = db;
        sb_fix_i = fix; ack_i = ack; clr_i = clr; rst_i = rst;
        @(posedge clk);
        #1;
        valid_i = 0; sb_err_i = 0; db_err_i = 0; sb_fix_i = 0;
        ack_i = 0; clr_i = 0; rst_i = 0;
    endtask

    initial begin
        repeat (3) tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        chk("rst_sb_cnt", 64'(sb_cnt_o), 0);
        chk("rst_log_valid", 64'(log_valid_o), 0);
        chk("rst_irq", 64'(irq_o), 0);

        for (int i = 0; i < 100; i++) tick(1, $urandom, 7'($urandom), 0, 0, 0, 0, 0, 0);
        chk("clean_sb_cnt", 64'(sb_cnt_o), 0);
        chk("clean_db_cnt", 64'(db_cnt_o), 0);
        chk("clean_log_valid", 64'(log_valid_o), 0);
        chk("clean_irq", 64'(irq_o), 0);

        tick(1, 32'h40, 7'h3, 0, 1, 0, 0, 0, 0);
        tick(1, 32'h44, 7'h5, 1, 0, 1, 0, 0, 0);
        tick(1, 32'h48, 7'h6, 1, 0, 1, 0, 0, 1);
        chk("midrst_db_cnt", 64'(db_cnt_o), 0);
        chk("midrst_log_valid", 64'(log_valid_o), 0);
        chk("midrst_log_addr", 64'(log_addr_o), 0);
        chk("midrst_irq", 64'(irq_o), 0);

        tick(1, 32'h100, 7'h25, 1, 0, 1, 0, 0, 0);
        chk("sb1_cnt", 64'(sb_cnt_o), 1);
        chk("sb1_valid", 64'(log_valid_o), 1);
        chk("sb1_addr", 64'(log_addr_o), 64'h100);
        chk("sb1_syn", 64'(log_syn_o), 64'h25);
        chk("sb1_fix", 64'(log_fix_o), 1);
        chk("sb1_db", 64'(log_db_o), 0);
        chk("sb1_irq", 64'(irq_o), 0);

        tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick(1, 32'h10, 7'h11, 1, 0, 0, 0, 0, 0);
        tick(1, 32'h20, 7'h22, 1, 1, 1, 0, 0, 0);
        chk("upg_addr", 64'(log_addr_o), 64'h20);
        chk("upg_db", 64'(log_db_o), 1);
        chk("upg_fix", 64'(log_fix_o), 0);
        chk("upg_ovf", 64'(ovf_o), 1);
        chk("upg_db_cnt", 64'(db_cnt_o), 1);
        chk("upg_irq", 64'(irq_o), 1);
        tick(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("ack_valid", 64'(log_valid_o), 0);
        chk("ack_ovf", 64'(ovf_o), 0);
        chk("ack_irq", 64'(irq_o), 1);
        chk("ack_addr_kept", 64'(log_addr_o), 64'h20);

        tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick(1, 32'(i), 7'(i), 1, 0, 0, 0, 0, 0);
        chk("thr3_sb_cnt", 64'(sb_cnt_o), 3);
        chk("thr3_irq", 64'(irq_o), 0);
        tick(1, 32'h3, 7'h3, 1, 0, 0, 0, 0, 0);
        chk("thr4_sb_cnt", 64'(sb_cnt_o), 4);
        chk("thr4_irq", 64'(irq_o), 1);

        tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) tick(1, 32'h200 + 32'(i), 7'h9, 1, 0, 0, 0, 0, 0);
        chk("sat_sb_cnt", 64'(sb_cnt_o), 15);
        chk("sat_log_addr", 64'(log_addr_o), 64'h200);
        tick(1, 32'h300, 7'h9, 1, 0, 0, 0, 0, 0);
        chk("sat_hold", 64'(sb_cnt_o), 15);

        tick(1, 32'h500, 7'h55, 0, 1, 0, 1, 0, 0);
        chk("ackdb_addr", 64'(log_addr_o), 64'h500);
        chk("ackdb_db", 64'(log_db_o), 1);
        chk("ackdb_ovf", 64'(ovf_o), 0);
        chk("ackdb_valid", 64'(log_valid_o), 1);
        tick(1, 32'h600, 7'h66, 1, 1, 0, 1, 0, 0);
        chk("ackdb2_addr", 64'(log_addr_o), 64'h600);

        tick(1, 32'h700, 7'h77, 1, 0, 1, 0, 1, 0);
        chk("clr_sb_cnt", 64'(sb_cnt_o), 0);
        chk("clr_db_cnt", 64'(db_cnt_o), 0);
        chk("clr_valid", 64'(log_valid_o), 0);
        chk("clr_irq", 64'(irq_o), 0);
        chk("clr_addr", 64'(log_addr_o), 0);

        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 3) != 0, $urandom, 7'($urandom),
                 ($urandom % 3) == 0, ($urandom % 8) == 0, $urandom_range(0, 1) == 1,
                 ($urandom % 6) == 0, ($urandom % 60) == 0, ($urandom % 300) == 0);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
